// File: rtl/flappy_pkg.sv
// Shared types and constants for the flappy game controller, physics and overlay.
// The game_state encoding is visible on the game_state output and must not change.
package flappy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAY    = 2'd1,
    ST_OVER    = 2'd2,
    ST_RESTART = 2'd3
  } game_state_e;

  localparam int DEFAULT_SCORE_W = 10;
  localparam int SCREEN_H        = 480;
  localparam int BIRD_H          = 32;

  // Counter width able to hold values 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/flappy_game_ctrl_if.sv
// Controller <-> datapath bundle: physics/pipe status in, tick/reset/score out.
// Optional hiscore signal exists only when FLAPPY_HISCORE_EN is defined.
interface flappy_game_ctrl_if
  import flappy_pkg::*;
#(
  parameter int SCORE_W = DEFAULT_SCORE_W
) ();

  // Handshake: phys_tick is a one-cycle strobe with no back-pressure; flap_req
  // is qualified by phys_tick and is don't-care in every other cycle.
  logic               bird_alive;
  logic               pipe_hit;
  logic               pipe_passed;
  logic               phys_tick;
  logic               flap_req;
  logic               phys_reset;
  logic               pipes_run;
  logic [SCORE_W-1:0] score;
  game_state_e        game_state;
`ifdef FLAPPY_HISCORE_EN
  logic [SCORE_W-1:0] hiscore;
`endif

  modport master (
    input  bird_alive, pipe_hit, pipe_passed,
    output phys_tick, flap_req, phys_reset, pipes_run, score, game_state
`ifdef FLAPPY_HISCORE_EN
    , output hiscore
`endif
  );

  modport slave (
    output bird_alive, pipe_hit, pipe_passed,
    input  phys_tick, flap_req, phys_reset, pipes_run, score, game_state
`ifdef FLAPPY_HISCORE_EN
    , input hiscore
`endif
  );

endinterface

// File: rtl/flappy_game_ctrl_flap_conditioner.sv
// Flap button synchronizer, rising-edge detector and pending-flap latch.
// A held button produces exactly one edge; the latch is consumed by a physics tick.
module flap_conditioner #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic flap_btn,
  input  logic accept,
  input  logic tick,
  output logic flap_edge,
  output logic flap_req
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   pending_q, pending_d;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], flap_btn};
    prev_d    = sync_q[SYNC_STAGES-1];
    flap_edge = sync_q[SYNC_STAGES-1] & ~prev_q;
    pending_d = pending_q;
    // A tick consumes the pending flap, including an edge arriving in the same cycle.
    if (tick) begin
      pending_d = 1'b0;
    end else if (flap_edge && accept) begin
      pending_d = 1'b1;
    end
    flap_req = pending_q | flap_edge;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '0;
      prev_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/flappy_game_ctrl.sv
// Game sequencer: IDLE/PLAY/OVER/RESTART FSM, physics tick divider, hold timer and score.
// Define FLAPPY_HISCORE_EN to add a high-score register latched on entry to OVER.
module flappy_game_ctrl
  import flappy_pkg::*;
#(
  parameter int FRAMES_PER_TICK  = 1,
  parameter int OVER_HOLD_FRAMES = 90,
  parameter int SCORE_W          = DEFAULT_SCORE_W,
  parameter int SYNC_STAGES      = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flap_btn,
  input  logic               frame_start,
  flappy_game_ctrl_if.master bus
);

  localparam int FCW = cnt_w(FRAMES_PER_TICK);
  localparam int HCW = cnt_w(OVER_HOLD_FRAMES + 1);

  game_state_e        state_q, state_d;
  logic [FCW-1:0]     frame_cnt_q, frame_cnt_d;
  logic [HCW-1:0]     hold_cnt_q, hold_cnt_d;
  logic               phys_tick_q, phys_tick_d;
  logic               alive_seen_q, alive_seen_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               flap_edge, cond_flap_req;
  logic               hold_done, accept, death, frame_wrap;

  flap_conditioner #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_flap (
    .clk       (clk),
    .reset     (reset),
    .flap_btn  (flap_btn),
    .accept    (accept),
    .tick      (phys_tick_q),
    .flap_edge (flap_edge),
    .flap_req  (cond_flap_req)
  );

  always_comb begin
    hold_done  = (hold_cnt_q == HCW'(OVER_HOLD_FRAMES));
    accept     = (state_q != ST_OVER) || hold_done;
    death      = bus.pipe_hit || (alive_seen_q && !bus.bird_alive);
    frame_wrap = (frame_cnt_q == FCW'(FRAMES_PER_TICK - 1));

    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    phys_tick_d  = 1'b0;
    alive_seen_d = alive_seen_q;
    score_d      = score_q;

    case (state_q)
      ST_IDLE: begin
        if (flap_edge) begin
          state_d = ST_PLAY;
          score_d = '0;
        end
      end
      ST_PLAY: begin
        if (bus.bird_alive) alive_seen_d = 1'b1;
        if (frame_start) begin
          frame_cnt_d = frame_wrap ? '0 : frame_cnt_q + 1'b1;
          phys_tick_d = frame_wrap && !death;
        end
        // A hit outranks a coincident pass; the score saturates rather than wraps.
        if (death) begin
          state_d = ST_OVER;
        end else if (bus.pipe_passed && (score_q != '1)) begin
          score_d = score_q + 1'b1;
        end
      end
      ST_OVER: begin
        if (frame_start && !hold_done) hold_cnt_d = hold_cnt_q + 1'b1;
        if (flap_edge && hold_done) begin
          state_d = ST_RESTART;
          score_d = '0;
        end
      end
      ST_RESTART: begin
        state_d = ST_PLAY;
        score_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_d == ST_PLAY) && (state_q != ST_PLAY)) begin
      frame_cnt_d  = '0;
      alive_seen_d = 1'b0;
    end
    if ((state_d == ST_OVER) && (state_q != ST_OVER)) hold_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      frame_cnt_q  <= '0;
      hold_cnt_q   <= '0;
      phys_tick_q  <= 1'b0;
      alive_seen_q <= 1'b0;
      score_q      <= '0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      phys_tick_q  <= phys_tick_d;
      alive_seen_q <= alive_seen_d;
      score_q      <= score_d;
    end
  end

`ifdef FLAPPY_HISCORE_EN
  logic [SCORE_W-1:0] hiscore_q, hiscore_d;

  always_comb begin
    hiscore_d = hiscore_q;
    if ((state_d == ST_OVER) && (state_q != ST_OVER) && (score_q > hiscore_q)) begin
      hiscore_d = score_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) hiscore_q <= '0;
    else       hiscore_q <= hiscore_d;
  end

  assign bus.hiscore = hiscore_q;
`endif

  // The bird stays frozen in OVER, so physics is held in reset only in IDLE and RESTART.
  assign bus.phys_reset = (state_q == ST_IDLE) || (state_q == ST_RESTART);
  assign bus.pipes_run  = (state_q == ST_PLAY);
  assign bus.phys_tick  = phys_tick_q;
  assign bus.flap_req   = cond_flap_req;
  assign bus.score      = score_q;
  assign bus.game_state = state_q;

endmodule
